// File: rtl/dram_burst_packer_pkg.sv
// Shared widths, derived packing constants and the packed-word FIFO record
// for the DRAM burst packer.
package dram_burst_packer_pkg;

  localparam int SAMPLE_W     = 32;
  localparam int MEM_W        = 128;
  localparam int ADX_W        = 27;
  localparam int ADX_STEP     = 8;
  localparam int FIFO_DEPTH   = 4;

  localparam int PACK         = MEM_W / SAMPLE_W;
  localparam int MASK_W       = MEM_W / 8;
  localparam int SAMPLE_BYTES = SAMPLE_W / 8;
  localparam int LANE_W       = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;

  typedef struct packed {
    logic [MEM_W-1:0]  data;
    logic [MASK_W-1:0] mask;
    logic [ADX_W-1:0]  adx;
  } fifo_entry_t;

  // Byte enables for the lowest `filled` sample lanes of a memory word.
  function automatic logic [MASK_W-1:0] lane_mask(input int filled);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < PACK; i++) begin
      if (i < filled) m[i*SAMPLE_BYTES +: SAMPLE_BYTES] = '1;
    end
    return m;
  endfunction

endpackage

// File: rtl/dram_burst_packer_fifo.sv
// Show-ahead FIFO of packed memory words; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module packer_fifo
  import dram_burst_packer_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  fifo_entry_t       push_entry,
  input  logic              pop,
  output fifo_entry_t       head,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              dropped
);

  fifo_entry_t      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             is_full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign is_full = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!is_full || do_pop);
  assign dropped = push && !do_push;
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the show-ahead outputs read as zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/dram_burst_packer.sv
// Packs narrow sampler words into memory-width words with byte enables and
// addresses, buffering them for a memory write interface.
module dram_burst_packer
  import dram_burst_packer_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              arm,
  input  logic [ADX_W-1:0]  start_adx,
  input  logic              we,
  input  logic [SAMPLE_W-1:0] write_data,
  input  logic              flush,
  output logic              full,
  output logic              overflow,
  output logic [MEM_W-1:0]  dram_data,
  output logic [MASK_W-1:0] dram_mask,
  output logic [ADX_W-1:0]  dram_adx,
  output logic              write_req,
  input  logic              write_allowed,
  output logic [31:0]       words_written
);

  logic [LANE_W-1:0] lane;
  logic [MEM_W-1:0]  acc_data;
  logic [ADX_W-1:0]  adx_cnt;
  logic [LANE_W:0]   filled;
  logic [MEM_W-1:0]  word_data;
  logic              push;
  fifo_entry_t       push_entry;
  fifo_entry_t       head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_dropped;

  // The incoming sample is merged before deciding whether to push, so a
  // flush coinciding with we emits the word including that sample.
  always_comb begin
    word_data = acc_data;
    for (int i = 0; i < PACK; i++) begin
      if (we && (lane == LANE_W'(i))) word_data[i*SAMPLE_W +: SAMPLE_W] = write_data;
    end
    filled = {1'b0, lane} + {{LANE_W{1'b0}}, we};
    push   = !arm && ((we && (lane == LANE_W'(PACK - 1))) || (flush && (filled != '0)));
    push_entry.data = word_data;
    push_entry.mask = lane_mask(int'(filled));
    push_entry.adx  = adx_cnt;
  end

  assign write_req = !fifo_empty && write_allowed;
  assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign dram_data = head.data;
  assign dram_mask = head.mask;
  assign dram_adx  = head.adx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lane          <= '0;
      acc_data      <= '0;
      adx_cnt       <= '0;
      overflow      <= 1'b0;
      words_written <= '0;
    end else if (arm) begin
      lane          <= '0;
      acc_data      <= '0;
      adx_cnt       <= start_adx;
      overflow      <= 1'b0;
      words_written <= '0;
    end else begin
      // A dropped word still consumes its address slot, leaving a visible gap.
      if (push) begin
        lane     <= '0;
        acc_data <= '0;
        adx_cnt  <= adx_cnt + ADX_W'(ADX_STEP);
      end else if (we) begin
        lane     <= lane + LANE_W'(1);
        acc_data <= word_data;
      end
      if (fifo_dropped) overflow <= 1'b1;
      if (write_req && (words_written != 32'hFFFF_FFFF)) words_written <= words_written + 32'd1;
    end
  end

  packer_fifo u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .push_entry (push_entry),
    .pop        (write_req),
    .head       (head),
    .count      (fifo_count),
    .empty      (fifo_empty),
    .dropped    (fifo_dropped)
  );

endmodule

// File: tb/tb_dram_burst_packer.sv
// Self-checking bench for dram_burst_packer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_dram_burst_packer;

  logic         clk = 1'b0;
  logic         resetn;
  logic         arm;
  logic [26:0]  start_adx;
  logic         we;
  logic [31:0]  write_data;
  logic         flush;
  logic         full;
  logic         overflow;
  logic [127:0] dram_data;
  logic [15:0]  dram_mask;
  logic [26:0]  dram_adx;
  logic         write_req;
  logic         write_allowed;
  logic [31:0]  words_written;

  always #5 clk = ~clk;

  dram_burst_packer dut (
    .clk           (clk),
    .resetn        (resetn),
    .arm           (arm),
    .start_adx     (start_adx),
    .we            (we),
    .write_data    (write_data),
    .flush         (flush),
    .full          (full),
    .overflow      (overflow),
    .dram_data     (dram_data),
    .dram_mask     (dram_mask),
    .dram_adx      (dram_adx),
    .write_req     (write_req),
    .write_allowed (write_allowed),
    .words_written (words_written)
  );

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  m;
    logic [26:0]  a;
  } ent_t;

  ent_t        mq[$];
  ent_t        seen[$];
  logic [31:0] ms[$];
  logic [26:0] m_adx;
  logic        m_ovf;
  logic [31:0] m_ww;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic ent_t mk(input logic [127:0] d, input logic [15:0] m, input logic [26:0] a);
    ent_t e;
    e.d = d; e.m = m; e.a = a;
    return e;
  endfunction

  function automatic logic [127:0] words4(input int base);
    return {32'(base + 3), 32'(base + 2), 32'(base + 1), 32'(base)};
  endfunction

  function automatic void model_reset();
    mq.delete(); ms.delete();
    m_adx = '0; m_ovf = 1'b0; m_ww = '0;
  endfunction

  // Reference: pending samples collect in a list; a word leaves when four
  // are held or a flush finds any, and is queued if the buffer has room.
  function automatic void model_step(input logic a, input logic [26:0] sa, input logic w,
                                     input logic [31:0] wd, input logic f, input logic wa);
    ent_t e;
    bit   pop;
    pop = (mq.size() > 0) && wa;
    if (pop) void'(mq.pop_front());
    if (a) begin
      ms.delete(); m_adx = sa; m_ovf = 1'b0; m_ww = '0;
      return;
    end
    if (pop && m_ww != 32'hFFFF_FFFF) m_ww = m_ww + 1;
    if (w) ms.push_back(wd);
    if (ms.size() == 4 || (f && ms.size() > 0)) begin
      e = mk('0, '0, m_adx);
      foreach (ms[k]) begin
        e.d[k*32 +: 32] = ms[k];
        e.m[k*4 +: 4]   = 4'hF;
      end
      if (mq.size() < 4) mq.push_back(e);
      else m_ovf = 1'b1;
      m_adx = m_adx + 27'd8;
      ms.delete();
    end
  endfunction

  task automatic cyc(input logic a, input logic [26:0] sa, input logic w,
                     input logic [31:0] wd, input logic f, input logic wa);
    arm = a; start_adx = sa; we = w; write_data = wd; flush = f; write_allowed = wa;
    #1;
    if (write_req) seen.push_back(mk(dram_data, dram_mask, dram_adx));
    @(posedge clk);
    model_step(a, sa, w, wd, f, wa);
    @(negedge clk);
  endtask

  task automatic samp(input int v, input logic wa);
    cyc(1'b0, '0, 1'b1, 32'(v), 1'b0, wa);
  endtask

  task automatic idle(input logic wa);
    cyc(1'b0, '0, 1'b0, '0, 1'b0, wa);
  endtask

  task automatic test_reset();
    resetn = 1'b0; arm = 0; start_adx = '0; we = 0; write_data = '0; flush = 0;
    write_allowed = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (write_req !== 1'b0) $display("FAIL reset_write_req got %0b want 0", write_req); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full got %0b want 0", full); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0b want 0", overflow); else n_pass++;
    n_checks++; if (words_written !== 32'd0) $display("FAIL reset_words got %0d want 0", words_written); else n_pass++;
    n_checks++; if (dram_data !== '0) $display("FAIL reset_data got %h want 0", dram_data); else n_pass++;
    n_checks++; if (dram_mask !== '0) $display("FAIL reset_mask got %h want 0", dram_mask); else n_pass++;
    n_checks++; if (dram_adx !== '0) $display("FAIL reset_adx got %h want 0", dram_adx); else n_pass++;
    resetn = 1'b1;
    model_reset();
    seen.delete();
    @(negedge clk);
  endtask

  task automatic test_full_word();
    ent_t exp;
    seen.delete();
    cyc(1'b1, 27'h100, 1'b0, '0, 1'b0, 1'b1);
    samp('h11, 1); samp('h22, 1); samp('h33, 1); samp('h44, 1);
    n_checks++; if (write_req !== 1'b1) $display("FAIL full_word_req_latency got %0b want 1", write_req); else n_pass++;
    repeat (2) idle(1);
    exp = mk(128'h00000044_00000033_00000022_00000011, 16'hFFFF, 27'h100);
    n_checks++; if (seen.size() != 1) $display("FAIL full_word_count got %0d want 1", seen.size()); else n_pass++;
    if (seen.size() > 0) begin
      n_checks++; if (seen[0] !== exp) $display("FAIL full_word_entry got %h want %h", seen[0], exp); else n_pass++;
    end
    n_checks++; if (words_written !== 32'd1) $display("FAIL full_word_words got %0d want 1", words_written); else n_pass++;
  endtask

  task automatic test_flush_partial();
    ent_t exp[4];
    seen.delete();
    cyc(1'b1, 27'h200, 1'b0, '0, 1'b0, 1'b1);
    samp('hA1, 1); samp('hA2, 1);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    samp('hB0, 1); samp('hB1, 1); samp('hB2, 1); samp('hB3, 1);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    samp('hC0, 1); samp('hC1, 1); samp('hC2, 1); samp('hC3, 1);
    samp('hD1, 1);
    cyc(1'b0, '0, 1'b1, 32'hD2, 1'b1, 1'b1);
    repeat (3) idle(1);
    exp[0] = mk({64'd0, 32'hA2, 32'hA1}, 16'h00FF, 27'h200);
    exp[1] = mk(words4('hB0), 16'hFFFF, 27'h208);
    exp[2] = mk(words4('hC0), 16'hFFFF, 27'h210);
    exp[3] = mk({64'd0, 32'hD2, 32'hD1}, 16'h00FF, 27'h218);
    n_checks++; if (seen.size() != 4) $display("FAIL flush_count got %0d want 4", seen.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (i < seen.size()) begin
        n_checks++;
        if (seen[i] !== exp[i]) $display("FAIL flush_entry%0d got %h want %h", i, seen[i], exp[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_overflow();
    seen.delete();
    cyc(1'b1, 27'h0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      samp(i, 0);
      if (i == 15) begin
        n_checks++; if (full !== 1'b0) $display("FAIL ovf_full_at15 got %0b want 0", full); else n_pass++;
      end
      if (i == 16) begin
        n_checks++; if (full !== 1'b1) $display("FAIL ovf_full_at16 got %0b want 1", full); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_early got %0b want 0", overflow); else n_pass++;
      end
    end
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got %0b want 1", overflow); else n_pass++;
    repeat (6) idle(1);
    for (int i = 21; i <= 24; i++) samp(i, 1);
    repeat (2) idle(1);
    n_checks++; if (seen.size() != 5) $display("FAIL ovf_count got %0d want 5", seen.size()); else n_pass++;
    for (int j = 0; j < 5; j++) begin
      if (j < seen.size()) begin
        n_checks++;
        if (seen[j] !== mk(words4(j == 4 ? 21 : 4*j + 1), 16'hFFFF, 27'(j == 4 ? 'h28 : 8*j)))
          $display("FAIL ovf_entry%0d got %h", j, seen[j]);
        else n_pass++;
      end
    end
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %0b want 1", overflow); else n_pass++;
    n_checks++; if (words_written !== 32'd5) $display("FAIL ovf_words got %0d want 5", words_written); else n_pass++;
  endtask

  task automatic test_push_pop_full();
    ent_t exp;
    seen.delete();
    cyc(1'b1, 27'h300, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 19; i++) samp(i, 0);
    n_checks++; if (full !== 1'b1) $display("FAIL pp_full_before got %0b want 1", full); else n_pass++;
    samp(20, 1);
    n_checks++; if (overflow !== 1'b0) $display("FAIL pp_overflow got %0b want 0", overflow); else n_pass++;
    n_checks++; if (full !== 1'b1) $display("FAIL pp_full_after got %0b want 1", full); else n_pass++;
    n_checks++; if (words_written !== 32'd1) $display("FAIL pp_words got %0d want 1", words_written); else n_pass++;
    repeat (6) idle(1);
    exp = mk(words4(17), 16'hFFFF, 27'h320);
    n_checks++; if (seen.size() != 5) $display("FAIL pp_count got %0d want 5", seen.size()); else n_pass++;
    if (seen.size() == 5) begin
      n_checks++; if (seen[4] !== exp) $display("FAIL pp_last got %h want %h", seen[4], exp); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    seen.delete();
    cyc(1'b1, 27'h7FFFFF8, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) samp(i, 1);
    repeat (2) idle(1);
    n_checks++; if (seen.size() != 2) $display("FAIL wrap_count got %0d want 2", seen.size()); else n_pass++;
    if (seen.size() == 2) begin
      n_checks++; if (seen[0] !== mk(words4(1), 16'hFFFF, 27'h7FFFFF8)) $display("FAIL wrap_first got %h", seen[0]); else n_pass++;
      n_checks++; if (seen[1] !== mk(words4(5), 16'hFFFF, 27'h0)) $display("FAIL wrap_second got %h", seen[1]); else n_pass++;
    end
  endtask

  task automatic test_arm_priority();
    seen.delete();
    cyc(1'b1, 27'h400, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) samp(i, 0);
    cyc(1'b1, 27'h500, 1'b1, 32'd7, 1'b1, 1'b0);
    for (int i = 8; i <= 11; i++) samp(i, 0);
    repeat (4) idle(1);
    n_checks++; if (seen.size() != 2) $display("FAIL arm_count got %0d want 2", seen.size()); else n_pass++;
    if (seen.size() == 2) begin
      n_checks++; if (seen[0] !== mk(words4(1), 16'hFFFF, 27'h400)) $display("FAIL arm_kept got %h", seen[0]); else n_pass++;
      n_checks++; if (seen[1] !== mk(words4(8), 16'hFFFF, 27'h500)) $display("FAIL arm_new got %h", seen[1]); else n_pass++;
    end
    n_checks++; if (overflow !== 1'b0) $display("FAIL arm_overflow got %0b want 0", overflow); else n_pass++;
  endtask

  task automatic test_reset_mid();
    seen.delete();
    cyc(1'b1, 27'h600, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 22; i++) samp(i, 0);
    n_checks++; if (overflow !== 1'b1 || full !== 1'b1) $display("FAIL rmid_pre got ovf=%0b full=%0b want 1 1", overflow, full); else n_pass++;
    write_allowed = 1'b1;
    #2 resetn = 1'b0;
    #1;
    n_checks++; if (write_req !== 1'b0) $display("FAIL rmid_req got %0b want 0", write_req); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL rmid_full got %0b want 0", full); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rmid_overflow got %0b want 0", overflow); else n_pass++;
    n_checks++; if (words_written !== 32'd0) $display("FAIL rmid_words got %0d want 0", words_written); else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    seen.delete();
    repeat (3) idle(1);
    n_checks++; if (seen.size() != 0) $display("FAIL rmid_no_writes got %0d want 0", seen.size()); else n_pass++;
    for (int i = 40; i <= 43; i++) samp(i, 1);
    repeat (2) idle(1);
    n_checks++; if (seen.size() != 1) $display("FAIL rmid_post_count got %0d want 1", seen.size()); else n_pass++;
    if (seen.size() == 1) begin
      n_checks++; if (seen[0] !== mk(words4(40), 16'hFFFF, 27'h0)) $display("FAIL rmid_post_entry got %h", seen[0]); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic a, w, f, wa;
    logic [26:0] sa;
    logic [31:0] wd;
    for (int i = 0; i < 600; i++) begin
      a  = ($urandom % 40) == 0;
      sa = 27'($urandom);
      w  = ($urandom % 4) != 0;
      wd = $urandom;
      f  = ($urandom % 6) == 0;
      wa = ((i / 50) % 2) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
      arm = a; start_adx = sa; we = w; write_data = wd; flush = f; write_allowed = wa;
      #1;
      n_checks++;
      if (write_req !== ((mq.size() > 0) && wa)) $display("FAIL rnd_req cyc %0d got %0b", i, write_req); else n_pass++;
      n_checks++;
      if (full !== (mq.size() == 4)) $display("FAIL rnd_full cyc %0d got %0b want %0b", i, full, mq.size() == 4); else n_pass++;
      n_checks++;
      if (overflow !== m_ovf) $display("FAIL rnd_overflow cyc %0d got %0b want %0b", i, overflow, m_ovf); else n_pass++;
      n_checks++;
      if (words_written !== m_ww) $display("FAIL rnd_words cyc %0d got %0d want %0d", i, words_written, m_ww); else n_pass++;
      if (mq.size() > 0) begin
        n_checks++;
        if (mk(dram_data, dram_mask, dram_adx) !== mq[0])
          $display("FAIL rnd_head cyc %0d got %h want %h", i, mk(dram_data, dram_mask, dram_adx), mq[0]);
        else n_pass++;
      end
      @(posedge clk);
      model_step(a, sa, w, wd, f, wa);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush_partial();
    test_overflow();
    test_push_pop_full();
    test_wrap();
    test_arm_priority();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
